// File: rtl/nvme_buffer_pkg.sv
// Shared types for the NVMe buffer read path: beat/keep types, reader states,
// and the FIFO entry that carries a RAM beat with its stream sideband.
package nvme_buffer_pkg;
  localparam int DW_PER_BEAT = 4;
  localparam int BEAT_BITS   = 128;

  typedef logic [BEAT_BITS-1:0]   beat_t;
  typedef logic [DW_PER_BEAT-1:0] keep_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t;

  typedef struct packed {
    logic  last;
    keep_t keep;
    beat_t data;
  } fifo_ent_t;

  // Dword enables for a beat, given its position within the request.
  function automatic keep_t beat_keep(input logic is_first, input logic is_final,
                                      input keep_t first_be, input keep_t last_be);
    keep_t k;
    if (is_first && is_final) k = first_be & last_be;
    else if (is_first)        k = first_be;
    else if (is_final)        k = last_be;
    else                      k = '1;
    return k;
  endfunction
endpackage

// File: rtl/nvme_buffer_rd_fifo.sv
// Synchronous FIFO with a registered head entry; count includes the head.
// Writes into an empty FIFO bypass the array and land directly in the head.
module nvme_buffer_rd_fifo
  import nvme_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  fifo_ent_t     wr_data_i,
  input  logic          rd_en_i,
  output logic          out_vld_o,
  output fifo_ent_t     out_data_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);

  fifo_ent_t       mem_q [DEPTH];
  fifo_ent_t       out_q;
  logic            out_vld_q;
  logic [PW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   mcnt_q;

  logic pop, load, take_mem, bypass, mem_wr;

  assign pop      = out_vld_q && rd_en_i;
  assign load     = !out_vld_q || pop;
  assign take_mem = load && (mcnt_q != '0);
  assign bypass   = load && (mcnt_q == '0) && wr_en_i;
  assign mem_wr   = wr_en_i && !bypass;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      mcnt_q    <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (mem_wr)   wp_q <= wp_q + 1'b1;
      if (take_mem) rp_q <= rp_q + 1'b1;
      mcnt_q <= mcnt_q + CW'(mem_wr) - CW'(take_mem);
      if (load) out_vld_q <= take_mem || bypass;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr)        mem_q[wp_q] <= wr_data_i;
    if (take_mem)      out_q <= mem_q[rp_q];
    else if (bypass)   out_q <= wr_data_i;
  end

  assign out_vld_o  = out_vld_q;
  assign out_data_o = out_q;
  assign count_o    = mcnt_q + CW'(out_vld_q);
endmodule

// File: rtl/nvme_buffer_reader.sv
// Reads a run of beats from the dword-enabled buffer RAM and streams them out
// with keep/last; credits (FIFO occupancy + in-flight read) throttle issue.
module nvme_buffer_reader
  import nvme_buffer_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [ADDR_BITS:0]   req_beats,
  input  logic [3:0]           req_first_be,
  input  logic [3:0]           req_last_be,
  output logic                 re,
  output logic [ADDR_BITS-1:0] raddr,
  input  logic [127:0]         rdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [127:0]         m_tdata,
  output logic [3:0]           m_tkeep,
  output logic                 m_tlast,
  output logic                 done
);
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  rd_state_t            state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   remain_q, remain_d;
  logic                 first_q, first_d;
  logic                 zdone_q, zdone_d;
  keep_t                fbe_q, fbe_d, lbe_q, lbe_d;

  logic                 vld_p1_q;
  keep_t                keep_p1_q;
  logic                 last_p1_q;

  logic [CW-1:0]        fifo_cnt;
  logic [CW:0]          outstanding;
  logic                 space, issue, is_final, hs, tlast_acc;
  fifo_ent_t            fifo_out, fifo_in;
  logic                 fifo_vld;

  assign outstanding = {1'b0, fifo_cnt} + {{CW{1'b0}}, vld_p1_q};
  assign space       = outstanding < (CW+1)'(OUT_DEPTH);
  assign issue       = !rst && (state_q == ISSUE) && space;
  assign is_final    = remain_q == (ADDR_BITS+1)'(1);
  assign req_ready   = !rst && (state_q == IDLE) && !zdone_q;
  assign hs          = req_valid && req_ready;
  assign tlast_acc   = m_tvalid && m_tready && m_tlast;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    first_d  = first_q;
    fbe_d    = fbe_q;
    lbe_d    = lbe_q;
    zdone_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (req_beats == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d  = ISSUE;
            addr_d   = req_addr;
            remain_d = req_beats;
            first_d  = 1'b1;
            fbe_d    = req_first_be;
            lbe_d    = req_last_be;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          first_d  = 1'b0;
          if (is_final) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tlast_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      first_q  <= 1'b0;
      zdone_q  <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      first_q  <= first_d;
      zdone_q  <= zdone_d;
      vld_p1_q <= issue;
    end
  end

  // Stage p0 -> p1: sideband for the read in flight, aligned with RAM latency
  always_ff @(posedge clk) begin
    fbe_q <= fbe_d;
    lbe_q <= lbe_d;
    if (issue) begin
      keep_p1_q <= beat_keep(first_q, is_final, fbe_q, lbe_q);
      last_p1_q <= is_final;
    end
  end

  assign re    = issue;
  assign raddr = addr_q;

  // Stage p1 -> FIFO: rdata joins its sideband
  assign fifo_in = '{last: last_p1_q, keep: keep_p1_q, data: rdata};

  nvme_buffer_rd_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (vld_p1_q),
    .wr_data_i  (fifo_in),
    .rd_en_i    (m_tready),
    .out_vld_o  (fifo_vld),
    .out_data_o (fifo_out),
    .count_o    (fifo_cnt)
  );

  assign m_tvalid = fifo_vld;
  assign m_tdata  = fifo_out.data;
  assign m_tkeep  = fifo_vld ? fifo_out.keep : '0;
  assign m_tlast  = fifo_vld && fifo_out.last;
  assign done     = !rst && (zdone_q || tlast_acc);
endmodule

// File: tb/tb_nvme_buffer_reader.sv
// Directed bench for nvme_buffer_reader with a 1-cycle-latency RAM model and
// a negedge stream monitor; expected beats come from the bench's own pattern.
module tb_nvme_buffer_reader;
  localparam int AB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AB-1:0] req_addr = '0;
  logic [AB:0]   req_beats = '0;
  logic [3:0]    req_first_be = '0;
  logic [3:0]    req_last_be = '0;
  logic          re;
  logic [AB-1:0] raddr;
  logic [127:0]  rdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [127:0]  m_tdata;
  logic [3:0]    m_tkeep;
  logic          m_tlast;
  logic          done;

  always #5 clk = ~clk;

  nvme_buffer_reader #(.ADDR_BITS(AB), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_beats(req_beats), .req_first_be(req_first_be),
    .req_last_be(req_last_be), .re(re), .raddr(raddr), .rdata(rdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic bp_mode = 1'b0;

  logic [127:0] mem [256];
  always @(posedge clk) if (re) rdata <= mem[raddr];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [127:0] pat(input int a, input logic [31:0] seed);
    logic [7:0] b;
    b = a[7:0];
    return {b, 8'h03, 16'hC0DE, b, 8'h02, 16'hC0DE,
            b, 8'h01, 16'hC0DE, b, 8'h00, 16'hC0DE} ^ {4{seed}};
  endfunction

  function automatic logic [3:0] exp_keep(input int i, input int n,
                                          input logic [3:0] f, input logic [3:0] l);
    if (n == 1) return f & l;
    if (i == 0) return f;
    if (i == n - 1) return l;
    return 4'hF;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [127:0] d;
    logic [3:0]   k;
    logic         l;
    logic         dn;
    int           c;
  } beat_s;

  beat_s        cap[$];
  int           re_addr[$];
  int           re_cyc[$];
  int           done_cnt = 0, done_cyc = 0, valid_cnt = 0, hs_cyc = 0;
  int           issued = 0, accepted = 0;
  logic         stall_arm = 1'b0;
  logic [127:0] st_d;
  logic [3:0]   st_k;
  logic         st_l;
  beat_s        mb;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst) begin
      issued = 0;
      accepted = 0;
      stall_arm = 1'b0;
    end else begin
      if (req_valid && req_ready) hs_cyc = cyc;
      if (re) begin
        chk("outstanding_le_depth", 128'(issued - accepted + 1 <= 4), 128'(1));
        re_addr.push_back(int'(raddr));
        re_cyc.push_back(cyc);
      end
      if (stall_arm) begin
        chk("stall_valid", 128'(m_tvalid), 128'(1));
        chk("stall_data", m_tdata, st_d);
        chk("stall_keep", 128'(m_tkeep), 128'(st_k));
        chk("stall_last", 128'(m_tlast), 128'(st_l));
      end
      if (m_tvalid) valid_cnt++;
      if (m_tvalid && m_tready) begin
        mb.d = m_tdata; mb.k = m_tkeep; mb.l = m_tlast; mb.dn = done; mb.c = cyc;
        cap.push_back(mb);
        accepted++;
      end
      if (re) issued++;
      stall_arm = m_tvalid && !m_tready;
      st_d = m_tdata; st_k = m_tkeep; st_l = m_tlast;
    end
  end

  task automatic clear();
    cap.delete(); re_addr.delete(); re_cyc.delete();
    done_cnt = 0; valid_cnt = 0;
  endtask

  task automatic load_mem(input logic [31:0] seed);
    for (int a = 0; a < 256; a++) mem[a] = pat(a, seed);
  endtask

  task automatic send(input int addr, input int beats, input logic [3:0] f, input logic [3:0] l);
    @(posedge clk); #1;
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    req_addr = AB'(addr); req_beats = (AB+1)'(beats);
    req_first_be = f; req_last_be = l; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    chk("done_within_budget", 128'(done_cnt != 0), 128'(1));
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic chk_reads(input string tag, input int base, input int n);
    chk($sformatf("%s_re_count", tag), 128'(re_addr.size()), 128'(n));
    for (int i = 0; i < n && i < re_addr.size(); i++)
      chk($sformatf("%s_raddr%0d", tag, i), 128'(re_addr[i]), 128'((base + i) & 255));
  endtask

  task automatic chk_stream(input string tag, input int base, input int n,
                            input logic [3:0] f, input logic [3:0] l, input logic [31:0] seed);
    chk($sformatf("%s_beat_count", tag), 128'(cap.size()), 128'(n));
    chk($sformatf("%s_done_count", tag), 128'(done_cnt), 128'(1));
    for (int i = 0; i < n && i < cap.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), cap[i].d, pat((base + i) & 255, seed));
      chk($sformatf("%s_keep%0d", tag, i), 128'(cap[i].k), 128'(exp_keep(i, n, f, l)));
      chk($sformatf("%s_last%0d", tag, i), 128'(cap[i].l), 128'(i == n - 1));
      chk($sformatf("%s_done%0d", tag, i), 128'(cap[i].dn), 128'(i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    load_mem(32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_re", 128'(re), 128'(0));
    chk("rst_raddr", 128'(raddr), 128'(0));
    chk("rst_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_tkeep", 128'(m_tkeep), 128'(0));
    chk("rst_tlast", 128'(m_tlast), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 128'(req_ready), 128'(1));

    // full-rate 8-beat read
    clear();
    send(8'h10, 8, 4'hF, 4'hF);
    wait_done(60);
    chk_reads("full", 8'h10, 8);
    chk_stream("full", 8'h10, 8, 4'hF, 4'hF, 32'h0);
    if (re_cyc.size() == 8 && cap.size() == 8) begin
      chk("full_first_re_cycle", 128'(re_cyc[0]), 128'(hs_cyc + 1));
      chk("full_first_beat_cycle", 128'(cap[0].c), 128'(hs_cyc + 3));
      for (int i = 1; i < 8; i++) begin
        chk($sformatf("full_re_contig%0d", i), 128'(re_cyc[i]), 128'(re_cyc[0] + i));
        chk($sformatf("full_beat_contig%0d", i), 128'(cap[i].c), 128'(cap[0].c + i));
      end
      chk("full_done_cycle", 128'(done_cyc), 128'(cap[7].c));
    end

    // edge keeps
    clear();
    send(8'h20, 3, 4'hC, 4'h3);
    wait_done(60);
    chk_reads("edge3", 8'h20, 3);
    chk_stream("edge3", 8'h20, 3, 4'hC, 4'h3, 32'h0);
    if (cap.size() == 3) chk("edge3_keep_mid_F", 128'(cap[1].k), 128'(4'hF));

    clear();
    send(8'h30, 1, 4'hE, 4'h7);
    wait_done(60);
    chk_reads("single", 8'h30, 1);
    chk_stream("single", 8'h30, 1, 4'hE, 4'h7, 32'h0);
    if (cap.size() == 1) chk("single_keep_6", 128'(cap[0].k), 128'(4'h6));

    // address wrap
    clear();
    send(8'hFE, 4, 4'hF, 4'hF);
    wait_done(60);
    chk_reads("wrap", 8'hFE, 4);
    chk_stream("wrap", 8'hFE, 4, 4'hF, 4'hF, 32'h0);

    // random backpressure over 32 beats
    clear();
    bp_mode = 1'b1;
    send(8'h40, 32, 4'h8, 4'h1);
    wait_done(600);
    bp_mode = 1'b0;
    chk_reads("bp", 8'h40, 32);
    chk_stream("bp", 8'h40, 32, 4'h8, 4'h1, 32'h0);

    // zero-length request
    clear();
    send(8'h00, 0, 4'hF, 4'hF);
    repeat (6) @(negedge clk);
    #1;
    chk("zero_done_count", 128'(done_cnt), 128'(1));
    chk("zero_done_cycle", 128'(done_cyc), 128'(hs_cyc + 1));
    chk("zero_no_reads", 128'(re_addr.size()), 128'(0));
    chk("zero_no_valid", 128'(valid_cnt), 128'(0));
    chk("zero_ready_after", 128'(req_ready), 128'(1));

    // reset after 3 of 8 beats
    clear();
    send(8'h80, 8, 4'hF, 4'hF);
    t = 0;
    while (cap.size() < 3 && t < 60) begin
      @(negedge clk); #1;
      t++;
    end
    chk("mid_rst_three_beats", 128'(cap.size()), 128'(3));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_re", 128'(re), 128'(0));
    chk("mid_rst_raddr", 128'(raddr), 128'(0));
    chk("mid_rst_tvalid", 128'(m_tvalid), 128'(0));
    chk("mid_rst_tkeep", 128'(m_tkeep), 128'(0));
    chk("mid_rst_tlast", 128'(m_tlast), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    chk("mid_rst_req_ready", 128'(req_ready), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_after", 128'(req_ready), 128'(1));
    repeat (5) @(negedge clk);
    #1;
    chk("mid_rst_no_done", 128'(done_cnt), 128'(0));
    chk("mid_rst_no_valid", 128'(m_tvalid), 128'(0));

    // fresh request after reset
    load_mem(32'h5A5A5A5A);
    clear();
    send(8'h80, 2, 4'h8, 4'h1);
    wait_done(60);
    chk_reads("fresh", 8'h80, 2);
    chk_stream("fresh", 8'h80, 2, 4'h8, 4'h1, 32'h5A5A5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
